// File: rtl/pwm11_gen.sv
// pwm11_gen: 2048-clock PWM with complementary drive and period sync pulse.
// Define PWM_DUTY_SHADOW_EN to latch duty only while idle or at period end.
module pwm11_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [10:0] duty,
    output logic        PWM_sig,
    output logic        PWM_sig_n,
    output logic        PWM_synch
);
    logic [10:0] r_cnt;
    logic [10:0] w_duty_act;
    logic        w_hi;
`ifdef PWM_DUTY_SHADOW_EN
    logic [10:0] r_duty_act;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_duty_act <= '0;
        else if (!en || r_cnt == 11'h7FF)
            r_duty_act <= duty;
    assign w_duty_act = r_duty_act;
`else
    assign w_duty_act = duty;
`endif
    assign w_hi = r_cnt < w_duty_act;
    // Idle parks the counter at 0 so the first enabled edge starts a period.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n || !en) begin
            r_cnt     <= '0;
            PWM_sig   <= 1'b0;
            PWM_sig_n <= 1'b0;
            PWM_synch <= 1'b0;
        end else begin
            r_cnt     <= r_cnt + 11'd1;
            PWM_sig   <= w_hi;
            PWM_sig_n <= !w_hi;
            PWM_synch <= r_cnt == 11'd0;
        end
endmodule

// File: tb/tb_pwm11_gen.sv
// tb_pwm11_gen: directed checks of duty, limits, shadowing, enable drop, reset, wrap.
module tb_pwm11_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [10:0] duty = '0;
    logic        PWM_sig, PWM_sig_n, PWM_synch;
    int          vectors = 0;
    int          errors = 0;
    int          hi, syn, both, cmpl, lo_idx, last_hi;
    logic        s0, p0;
`ifdef PWM_DUTY_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    pwm11_gen dut (
        .clk(clk), .rst_n(rst_n), .en(en), .duty(duty),
        .PWM_sig(PWM_sig), .PWM_sig_n(PWM_sig_n), .PWM_synch(PWM_synch)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic [10:0] d);
        duty = d;
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
    endtask

    // Samples one full period starting at its first output clock; optionally
    // changes duty after sampling output clock chg.
    task automatic run_period(input int chg, input logic [10:0] nd);
        hi = 0; syn = 0; both = 0; cmpl = 0; lo_idx = -1; last_hi = -1;
        s0 = PWM_synch; p0 = PWM_sig;
        for (int i = 0; i < 2048; i++) begin
            hi += int'(PWM_sig);
            syn += int'(PWM_synch);
            both += int'(PWM_sig && PWM_sig_n);
            cmpl += int'(PWM_sig_n === !PWM_sig);
            if (PWM_sig) last_hi = i;
            else lo_idx = i;
            if (i == chg) duty = nd;
            tick();
        end
    endtask

    task automatic test_reset();
        en = 1'b1; duty = 11'd512;
        tick(); tick();
        vectors += 3;
        if (PWM_sig !== 1'b0) begin errors++; $display("FAIL reset_sig got %b want 0", PWM_sig); end
        if (PWM_sig_n !== 1'b0) begin errors++; $display("FAIL reset_sig_n got %b want 0", PWM_sig_n); end
        if (PWM_synch !== 1'b0) begin errors++; $display("FAIL reset_synch got %b want 0", PWM_synch); end
        en = 1'b0;
        rst_n = 1'b1;
        tick(); tick();
        vectors += 2;
        if (PWM_sig_n !== 1'b0) begin errors++; $display("FAIL idle_sig_n got %b want 0", PWM_sig_n); end
        if (PWM_synch !== 1'b0) begin errors++; $display("FAIL idle_synch got %b want 0", PWM_synch); end
    endtask

    task automatic test_basic();
        restart(11'd512);
        for (int p = 0; p < 2; p++) begin
            run_period(-1, '0);
            vectors += 6;
            if (hi != 512) begin errors++; $display("FAIL basic_hi p%0d got %0d want 512", p, hi); end
            if (last_hi != 511) begin errors++; $display("FAIL basic_last_hi p%0d got %0d want 511", p, last_hi); end
            if (cmpl != 2048) begin errors++; $display("FAIL basic_cmpl p%0d got %0d want 2048", p, cmpl); end
            if (syn != 1) begin errors++; $display("FAIL basic_syn p%0d got %0d want 1", p, syn); end
            if (s0 !== 1'b1) begin errors++; $display("FAIL basic_syn_pos p%0d got %b want 1", p, s0); end
            if (p0 !== 1'b1) begin errors++; $display("FAIL basic_rise p%0d got %b want 1", p, p0); end
        end
    endtask

    task automatic test_limits();
        restart(11'd0);
        run_period(-1, '0);
        vectors += 3;
        if (hi != 0) begin errors++; $display("FAIL d0_hi got %0d want 0", hi); end
        if (cmpl != 2048) begin errors++; $display("FAIL d0_sig_n got %0d want 2048", cmpl); end
        if (syn != 1) begin errors++; $display("FAIL d0_syn got %0d want 1", syn); end
        restart(11'd2047);
        run_period(-1, '0);
        vectors += 4;
        if (hi != 2047) begin errors++; $display("FAIL d2047_hi got %0d want 2047", hi); end
        if (lo_idx != 2047) begin errors++; $display("FAIL d2047_lo_idx got %0d want 2047", lo_idx); end
        if (both != 0) begin errors++; $display("FAIL d2047_overlap got %0d want 0", both); end
        if (cmpl != 2048) begin errors++; $display("FAIL d2047_cmpl got %0d want 2048", cmpl); end
    endtask

    task automatic test_shadow();
        restart(11'd512);
        run_period(100, 11'd1024);
        vectors += 2;
        if (hi != (SHADOW ? 512 : 1024))
            begin errors++; $display("FAIL shadow_cur got %0d want %0d", hi, SHADOW ? 512 : 1024); end
        if (syn != 1) begin errors++; $display("FAIL shadow_syn got %0d want 1", syn); end
        run_period(-1, '0);
        vectors += 1;
        if (hi != 1024) begin errors++; $display("FAIL shadow_next got %0d want 1024", hi); end
    endtask

    task automatic test_enable_drop();
        restart(11'd512);
        repeat (300) tick();
        vectors += 1;
        if (PWM_sig !== 1'b1) begin errors++; $display("FAIL drop_pre got %b want 1", PWM_sig); end
        en = 1'b0;
        tick();
        vectors += 3;
        if (PWM_sig !== 1'b0) begin errors++; $display("FAIL drop_sig got %b want 0", PWM_sig); end
        if (PWM_sig_n !== 1'b0) begin errors++; $display("FAIL drop_sig_n got %b want 0", PWM_sig_n); end
        if (PWM_synch !== 1'b0) begin errors++; $display("FAIL drop_synch got %b want 0", PWM_synch); end
        en = 1'b1;
        tick();
        run_period(-1, '0);
        vectors += 3;
        if (s0 !== 1'b1) begin errors++; $display("FAIL reen_synch got %b want 1", s0); end
        if (hi != 512) begin errors++; $display("FAIL reen_hi got %0d want 512", hi); end
        if (syn != 1) begin errors++; $display("FAIL reen_syn got %0d want 1", syn); end
    endtask

    task automatic test_async_reset();
        restart(11'd512);
        repeat (10) tick();
        vectors += 1;
        if (PWM_sig !== 1'b1) begin errors++; $display("FAIL ar_pre got %b want 1", PWM_sig); end
        #2 rst_n = 1'b0;
        #1;
        vectors += 3;
        if (PWM_sig !== 1'b0) begin errors++; $display("FAIL ar_sig got %b want 0", PWM_sig); end
        if (PWM_sig_n !== 1'b0) begin errors++; $display("FAIL ar_sig_n got %b want 0", PWM_sig_n); end
        if (PWM_synch !== 1'b0) begin errors++; $display("FAIL ar_synch got %b want 0", PWM_synch); end
        #1 rst_n = 1'b1;
        tick();
        run_period(-1, '0);
        vectors += 4;
        if (s0 !== 1'b1) begin errors++; $display("FAIL ar_first_synch got %b want 1", s0); end
        if (syn != 1) begin errors++; $display("FAIL ar_syn got %0d want 1", syn); end
        if (hi != (SHADOW ? 0 : 512))
            begin errors++; $display("FAIL ar_hi got %0d want %0d", hi, SHADOW ? 0 : 512); end
        if (PWM_synch !== 1'b1) begin errors++; $display("FAIL ar_next_synch got %b want 1", PWM_synch); end
    endtask

    task automatic test_wrap();
        restart(11'd1);
        for (int p = 0; p < 3; p++) begin
            run_period(-1, '0);
            vectors += 4;
            if (hi != 1) begin errors++; $display("FAIL wrap_hi p%0d got %0d want 1", p, hi); end
            if (p0 !== 1'b1) begin errors++; $display("FAIL wrap_first p%0d got %b want 1", p, p0); end
            if (syn != 1) begin errors++; $display("FAIL wrap_syn p%0d got %0d want 1", p, syn); end
            if (s0 !== 1'b1) begin errors++; $display("FAIL wrap_syn_pos p%0d got %b want 1", p, s0); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_limits();
        test_shadow();
        test_enable_drop();
        test_async_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
